// File: rtl/irq_priority_resolver_if.sv
// Bus between the 8259A control logic and the IRR/ISR/priority resolver.
// The master side (control logic) drives requests, mask, mode and acknowledges.
interface irq_priority_resolver_if;
  logic [7:0] IR;
  logic [7:0] IM;
  logic       LTIM;
  logic       AEOI;
  logic [7:0] ocw2;
  logic       ocw2_valid;
  logic       first_ACK;
  logic       second_ACK;
  logic       INT;
  logic [2:0] INT_VEC;
  logic [7:0] IRR;
  logic [7:0] ISR;

  modport master (
    output IR, IM, LTIM, AEOI, ocw2, ocw2_valid, first_ACK, second_ACK,
    input  INT, INT_VEC, IRR, ISR
  );

  modport slave (
    input  IR, IM, LTIM, AEOI, ocw2, ocw2_valid, first_ACK, second_ACK,
    output INT, INT_VEC, IRR, ISR
  );
endinterface

// File: rtl/irq_priority_resolver.sv
// 8259A IRR/ISR stage: request latching, rotating priority resolution against the
// in-service register, INTA vector capture, OCW2 EOI/rotation and automatic EOI.
module irq_priority_resolver #(
  parameter int         NUM_IR       = 8,
  parameter logic [2:0] SPURIOUS_VEC = 3'd7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  irq_priority_resolver_if.slave     bus
);

  logic [NUM_IR-1:0] ir_q, irr_q, isr_q;
  logic [NUM_IR-1:0] irr_n, isr_n, req;
  logic              int_q;
  logic [2:0]        vec_q, vec_n;
  logic [2:0]        lowest, lowest_n;
  logic              rot_aeoi, rot_n;
  logic              ack1_q, ack2_q;
  logic              spur_q, spur_n;
  logic              ack1_rise, ack2_fall;
  logic              req_found, isr_found, qualify, ocw_rot;
  logic [2:0]        best_req, best_isr;
  logic [2:0]        lvl;
  logic              unused_ok;

  // Rank 0 is the highest priority, i.e. the IR just after 'lowest'.
  function automatic logic [2:0] rank(input logic [2:0] idx, input logic [2:0] low);
    return idx - low - 3'd1;
  endfunction

  // Returns {found, index} of the highest-priority set bit under the current rotation.
  function automatic logic [3:0] find_best(input logic [7:0] v, input logic [2:0] low);
    logic [3:0] r;
    logic [2:0] idx;
    r = '0;
    for (int k = 7; k >= 0; k--) begin
      idx = low + 3'd1 + k[2:0];
      if (v[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  assign lvl       = bus.ocw2[2:0];
  assign unused_ok = ^bus.ocw2[4:3];
  assign ack1_rise = bus.first_ACK & ~ack1_q;
  assign ack2_fall = ~bus.second_ACK & ack2_q;

  always_comb begin
    req                   = irr_q & ~bus.IM;
    {req_found, best_req} = find_best(req, lowest);
    {isr_found, best_isr} = find_best(isr_q, lowest);
    qualify = req_found && (!isr_found || (rank(best_req, lowest) < rank(best_isr, lowest)));

    irr_n    = bus.LTIM ? bus.IR : (irr_q | (bus.IR & ~ir_q));
    isr_n    = isr_q;
    lowest_n = lowest;
    rot_n    = rot_aeoi;
    vec_n    = vec_q;
    spur_n   = spur_q;
    ocw_rot  = 1'b0;

    if (bus.ocw2_valid) begin
      case (bus.ocw2[7:5])
        3'b001: if (isr_found) isr_n[best_isr] = 1'b0;
        3'b101: if (isr_found) begin
          isr_n[best_isr] = 1'b0;
          lowest_n        = best_isr;
          ocw_rot         = 1'b1;
        end
        3'b011: isr_n[lvl] = 1'b0;
        3'b111: begin
          isr_n[lvl] = 1'b0;
          lowest_n   = lvl;
          ocw_rot    = 1'b1;
        end
        3'b110: begin
          lowest_n = lvl;
          ocw_rot  = 1'b1;
        end
        3'b100:  rot_n = 1'b1;
        3'b000:  rot_n = 1'b0;
        default: ;
      endcase
    end

    if (ack2_fall && bus.AEOI && !spur_q) begin
      isr_n[vec_q] = 1'b0;
      if (rot_aeoi && !ocw_rot) lowest_n = vec_q;
    end

    // Acknowledge set comes last so it wins over any clear of the same bit.
    if (ack1_rise) begin
      if (qualify) begin
        isr_n[best_req] = 1'b1;
        irr_n[best_req] = 1'b0;
        vec_n           = best_req;
        spur_n          = 1'b0;
      end else begin
        vec_n  = SPURIOUS_VEC;
        spur_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q     <= '0;
      irr_q    <= '0;
      isr_q    <= '0;
      int_q    <= 1'b0;
      vec_q    <= 3'd0;
      lowest   <= 3'd7;
      rot_aeoi <= 1'b0;
      ack1_q   <= 1'b0;
      ack2_q   <= 1'b0;
      spur_q   <= 1'b0;
    end else begin
      ir_q     <= bus.IR;
      irr_q    <= irr_n;
      isr_q    <= isr_n;
      int_q    <= qualify;
      vec_q    <= vec_n;
      lowest   <= lowest_n;
      rot_aeoi <= rot_n;
      ack1_q   <= bus.first_ACK;
      ack2_q   <= bus.second_ACK;
      spur_q   <= spur_n;
    end
  end

  assign bus.IRR     = irr_q;
  assign bus.ISR     = isr_q;
  assign bus.INT     = int_q;
  assign bus.INT_VEC = vec_q;

endmodule

// File: tb/tb_irq_priority_resolver.sv
// Directed cycle-by-cycle vectors for the IRR/ISR priority resolver plus an
// asynchronous reset issued in the middle of an acknowledge.
module tb_irq_priority_resolver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  irq_priority_resolver_if bus ();

  irq_priority_resolver #(.NUM_IR(8), .SPURIOUS_VEC(3'd7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] ir;
    logic [7:0] im;
    logic       ltim;
    logic       aeoi;
    logic [7:0] ocw2;
    logic       ov;
    logic       fa;
    logic       sa;
    logic [7:0] e_irr;
    logic [7:0] e_isr;
    logic       e_int;
    logic [2:0] e_vec;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [7:0] ir, input logic [7:0] im, input logic ltim,
                     input logic aeoi, input logic [7:0] ocw2, input logic ov,
                     input logic fa, input logic sa, input logic [7:0] e_irr,
                     input logic [7:0] e_isr, input logic e_int, input logic [2:0] e_vec);
    vec_t v;
    v = '{ir, im, ltim, aeoi, ocw2, ov, fa, sa, e_irr, e_isr, e_int, e_vec};
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [7:0] act,
                     input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.IR = 8'h00; bus.IM = 8'h00; bus.LTIM = 1'b0; bus.AEOI = 1'b0;
    bus.ocw2 = 8'h00; bus.ocw2_valid = 1'b0; bus.first_ACK = 1'b0; bus.second_ACK = 1'b0;
  endtask

  task automatic check_all(input string tag, input int row, input logic [7:0] irr,
                           input logic [7:0] isr, input logic intr, input logic [2:0] vec);
    chk({tag, ".IRR"}, row, bus.IRR, irr);
    chk({tag, ".ISR"}, row, bus.ISR, isr);
    chk({tag, ".INT"}, row, {7'd0, bus.INT}, {7'd0, intr});
    chk({tag, ".VEC"}, row, {5'd0, bus.INT_VEC}, {5'd0, vec});
  endtask

  initial begin
    drive_idle();

    //   ir     im     lt  ae  ocw2   ov  fa  sa   irr    isr    int vec
    // edge mode single request, manual EOI
    add(8'h08, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h08, 8'h00, 0, 0);
    add(8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h08, 8'h00, 1, 0);
    add(8'h00, 8'h00, 0, 0, 8'h00, 0, 1, 0, 8'h00, 8'h08, 1, 3);
    add(8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h08, 0, 3);
    add(8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h08, 0, 3);
    add(8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h08, 0, 3);
    add(8'h00, 8'h00, 0, 0, 8'h20, 1, 0, 0, 8'h00, 8'h00, 0, 3);
    add(8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 3);
    // nesting: IR5 in service blocks IR6, IR2 preempts
    add(8'h20, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h20, 8'h00, 0, 3);
    add(8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h20, 8'h00, 1, 3);
    add(8'h00, 8'h00, 0, 0, 8'h00, 0, 1, 0, 8'h00, 8'h20, 1, 5);
    add(8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h20, 0, 5);
    add(8'h40, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h40, 8'h20, 0, 5);
    add(8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h40, 8'h20, 0, 5);
    add(8'h04, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h44, 8'h20, 0, 5);
    add(8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h44, 8'h20, 1, 5);
    add(8'h00, 8'h00, 0, 0, 8'h00, 0, 1, 0, 8'h40, 8'h24, 1, 2);
    add(8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h40, 8'h24, 0, 2);
    add(8'h00, 8'h00, 0, 0, 8'h20, 1, 0, 0, 8'h40, 8'h20, 0, 2);
    add(8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h40, 8'h20, 0, 2);
    add(8'h00, 8'h00, 0, 0, 8'h20, 1, 0, 0, 8'h40, 8'h00, 0, 2);
    add(8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h40, 8'h00, 1, 2);
    add(8'h00, 8'h00, 0, 0, 8'h00, 0, 1, 0, 8'h00, 8'h40, 1, 6);
    add(8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h40, 0, 6);
    add(8'h00, 8'h00, 0, 0, 8'h66, 1, 0, 0, 8'h00, 8'h00, 0, 6);
    // mask holds off INT until released
    add(8'h10, 8'h10, 0, 0, 8'h00, 0, 0, 0, 8'h10, 8'h00, 0, 6);
    add(8'h00, 8'h10, 0, 0, 8'h00, 0, 0, 0, 8'h10, 8'h00, 0, 6);
    add(8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h10, 8'h00, 1, 6);
    add(8'h00, 8'h00, 0, 0, 8'h00, 0, 1, 0, 8'h00, 8'h10, 1, 4);
    add(8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h10, 0, 4);
    add(8'h00, 8'h00, 0, 0, 8'h20, 1, 0, 0, 8'h00, 8'h00, 0, 4);
    // set priority L=4, then rotate on non-specific EOI
    add(8'h00, 8'h00, 0, 0, 8'hC4, 1, 0, 0, 8'h00, 8'h00, 0, 4);
    add(8'h41, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h41, 8'h00, 0, 4);
    add(8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h41, 8'h00, 1, 4);
    add(8'h00, 8'h00, 0, 0, 8'h00, 0, 1, 0, 8'h01, 8'h40, 1, 6);
    add(8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h01, 8'h40, 0, 6);
    add(8'h00, 8'h00, 0, 0, 8'hA0, 1, 0, 0, 8'h01, 8'h00, 0, 6);
    add(8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h01, 8'h00, 1, 6);
    add(8'h80, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h81, 8'h00, 1, 6);
    add(8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h81, 8'h00, 1, 6);
    add(8'h00, 8'h00, 0, 0, 8'h00, 0, 1, 0, 8'h01, 8'h80, 1, 7);
    add(8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h01, 8'h80, 0, 7);
    add(8'h00, 8'h00, 0, 0, 8'h67, 1, 0, 0, 8'h01, 8'h00, 0, 7);
    add(8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h01, 8'h00, 1, 7);
    add(8'h00, 8'h00, 0, 0, 8'h00, 0, 1, 0, 8'h00, 8'h01, 1, 0);
    add(8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h01, 0, 0);
    add(8'h00, 8'h00, 0, 0, 8'h20, 1, 0, 0, 8'h00, 8'h00, 0, 0);
    add(8'h00, 8'h00, 0, 0, 8'hC7, 1, 0, 0, 8'h00, 8'h00, 0, 0);
    // AEOI with rotation: service IR1, then IR2 beats IR1
    add(8'h00, 8'h00, 0, 1, 8'h80, 1, 0, 0, 8'h00, 8'h00, 0, 0);
    add(8'h02, 8'h00, 0, 1, 8'h00, 0, 0, 0, 8'h02, 8'h00, 0, 0);
    add(8'h00, 8'h00, 0, 1, 8'h00, 0, 0, 0, 8'h02, 8'h00, 1, 0);
    add(8'h00, 8'h00, 0, 1, 8'h00, 0, 1, 0, 8'h00, 8'h02, 1, 1);
    add(8'h00, 8'h00, 0, 1, 8'h00, 0, 0, 0, 8'h00, 8'h02, 0, 1);
    add(8'h00, 8'h00, 0, 1, 8'h00, 0, 0, 1, 8'h00, 8'h02, 0, 1);
    add(8'h00, 8'h00, 0, 1, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 1);
    add(8'h06, 8'h00, 0, 1, 8'h00, 0, 0, 0, 8'h06, 8'h00, 0, 1);
    add(8'h00, 8'h00, 0, 1, 8'h00, 0, 0, 0, 8'h06, 8'h00, 1, 1);
    add(8'h00, 8'h00, 0, 1, 8'h00, 0, 1, 0, 8'h02, 8'h04, 1, 2);
    add(8'h00, 8'h00, 0, 1, 8'h00, 0, 0, 0, 8'h02, 8'h04, 0, 2);
    add(8'h00, 8'h00, 0, 1, 8'h00, 0, 0, 1, 8'h02, 8'h04, 0, 2);
    add(8'h00, 8'h00, 0, 1, 8'h00, 0, 0, 0, 8'h02, 8'h00, 0, 2);
    add(8'h00, 8'h00, 0, 1, 8'h00, 1, 0, 0, 8'h02, 8'h00, 1, 2);
    add(8'h00, 8'h00, 0, 1, 8'h00, 0, 1, 0, 8'h00, 8'h02, 1, 1);
    add(8'h00, 8'h00, 0, 1, 8'h00, 0, 0, 0, 8'h00, 8'h02, 0, 1);
    add(8'h00, 8'h00, 0, 1, 8'h00, 0, 0, 1, 8'h00, 8'h02, 0, 1);
    add(8'h00, 8'h00, 0, 1, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 1);
    add(8'h00, 8'h00, 0, 0, 8'hC7, 1, 0, 0, 8'h00, 8'h00, 0, 1);
    // level mode: dropped request gives spurious vector
    add(8'h80, 8'h00, 1, 0, 8'h00, 0, 0, 0, 8'h80, 8'h00, 0, 1);
    add(8'h80, 8'h00, 1, 0, 8'h00, 0, 0, 0, 8'h80, 8'h00, 1, 1);
    add(8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 1);
    add(8'h00, 8'h00, 1, 0, 8'h00, 0, 1, 0, 8'h00, 8'h00, 0, 7);
    add(8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 7);
    add(8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 1, 8'h00, 8'h00, 0, 7);
    add(8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 7);
    // level mode: held request re-sets IRR after acknowledge
    add(8'h08, 8'h00, 1, 0, 8'h00, 0, 0, 0, 8'h08, 8'h00, 0, 7);
    add(8'h08, 8'h00, 1, 0, 8'h00, 0, 0, 0, 8'h08, 8'h00, 1, 7);
    add(8'h08, 8'h00, 1, 0, 8'h00, 0, 1, 0, 8'h00, 8'h08, 1, 3);
    add(8'h08, 8'h00, 1, 0, 8'h00, 0, 0, 0, 8'h08, 8'h08, 0, 3);
    add(8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h08, 0, 3);
    add(8'h00, 8'h00, 0, 0, 8'h20, 1, 0, 0, 8'h00, 8'h00, 0, 3);

    repeat (2) @(posedge clk);
    #1;
    check_all("reset", -1, 8'h00, 8'h00, 1'b0, 3'd0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      bus.IR         = tbl[i].ir;
      bus.IM         = tbl[i].im;
      bus.LTIM       = tbl[i].ltim;
      bus.AEOI       = tbl[i].aeoi;
      bus.ocw2       = tbl[i].ocw2;
      bus.ocw2_valid = tbl[i].ov;
      bus.first_ACK  = tbl[i].fa;
      bus.second_ACK = tbl[i].sa;
      @(posedge clk);
      #1;
      check_all("vec", i, tbl[i].e_irr, tbl[i].e_isr, tbl[i].e_int, tbl[i].e_vec);
    end

    // asynchronous reset in the middle of an acknowledge
    drive_idle();
    bus.IR = 8'h20;
    @(posedge clk); #1;
    bus.IR = 8'h00;
    @(posedge clk); #1;
    chk("pre_rst.INT", 0, {7'd0, bus.INT}, 8'h01);
    bus.first_ACK = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst.ISR", 0, bus.ISR, 8'h20);
    bus.first_ACK  = 1'b0;
    bus.second_ACK = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    check_all("mid_rst", 0, 8'h00, 8'h00, 1'b0, 3'd0);
    bus.second_ACK = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all("post_rst", 0, 8'h00, 8'h00, 1'b0, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/irq_priority_resolver.md
Name: irq_priority_resolver

Overview:
- Clocked IRR/ISR/priority stage of the 8259A model, sitting directly upstream of the control logic.
- Latches interrupt requests into IRR and applies the mask from the control logic.
- Resolves the highest-priority unmasked request against the in-service register and drives INT and INT_VEC[2:0], which the control logic uses to build the vector byte.
- Executes OCW2 EOI/rotation commands and automatic EOI.

Parameters:
- NUM_IR, 8, number of interrupt request lines (fixed at 8; the vector width is 3).
- SPURIOUS_VEC, 3'd7, vector reported when nothing is pending at the first acknowledge.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- IR  input  8  interrupt request lines, synchronous to clk.
- IM  input  8  interrupt mask register; 1 = masked.
- LTIM  input  1  1 = level-triggered, 0 = edge-triggered.
- AEOI  input  1  automatic end-of-interrupt enable.
- ocw2  input  8  OCW2 byte: [7:5] = R,SL,EOI; [2:0] = level L.
- ocw2_valid  input  1  one-cycle strobe; ocw2 is valid.
- first_ACK  input  1  level, high during the first INTA pulse.
- second_ACK  input  1  level, high during the second INTA pulse.
- INT  output  1  interrupt request to the CPU.
- INT_VEC  output  3  IR number being serviced.
- IRR  output  8  interrupt request register.
- ISR  output  8  in-service register.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low (rst_n). Reset values:
  - IRR = 0, ISR = 0, ir_q = 0, INT = 0, INT_VEC = 0.
  - lowest = 3'd7, so IR0 has the highest priority.
  - rot_aeoi = 0; ack1_q and ack2_q = 0.
  - Reset mid-acknowledge abandons the cycle; no ISR bit survives.
- ir_q registers IR every cycle.
- IRR set, edge mode (LTIM = 0): IRR[i] sets when IR[i] = 1 and ir_q[i] = 0. A bit can re-arm only after IR[i] has been low for at least one sampled cycle.
- IRR, level mode (LTIM = 1): IRR[i] follows IR[i] every cycle; dropping IR clears IRR before acknowledge.
- Priority order: IR(lowest+1 mod 8) is highest, wrapping round to IR(lowest), which is lowest. All comparisons are done on bit positions rotated relative to lowest.
- Pending set: req = IRR & ~IM. best_req = highest-priority set bit of req.
- Fully nested check: a request qualifies only if it is strictly higher priority than the highest set ISR bit. Masked bits still in ISR continue to block lower-priority requests.
- INT: registered. It goes high the cycle after a qualifying request exists and low the cycle after none exists. An IR rising edge therefore gives INT two clocks later.
- First acknowledge (rising edge of first_ACK, detected via ack1_q):
  - If a qualifying request exists: INT_VEC <= best_req, ISR[best_req] <= 1, IRR[best_req] <= 0 (in level mode the bit re-sets next cycle while IR stays high).
  - If none exists: INT_VEC <= SPURIOUS_VEC and ISR is unchanged.
- INT_VEC holds from the first acknowledge through the falling edge of second_ACK.
- AEOI: on the falling edge of second_ACK, if AEOI = 1, ISR[INT_VEC] <= 0. If rot_aeoi = 1 as well, lowest <= INT_VEC. A spurious cycle clears nothing.
- OCW2 actions, on ocw2_valid, decoded from ocw2[7:5]:
  - 001 non-specific EOI: clear the highest-priority set ISR bit.
  - 011 specific EOI: clear ISR[L].
  - 101 rotate on non-specific EOI: clear the highest-priority set ISR bit b, then lowest <= b.
  - 111 rotate on specific EOI: clear ISR[L], then lowest <= L.
  - 110 set priority: lowest <= L.
  - 100: rot_aeoi <= 1.
  - 000: rot_aeoi <= 0.
  - 010: no-op.
  - An EOI with ISR = 0 is a no-op; for 101 with ISR = 0, lowest is also unchanged.
- Simultaneous events in one cycle:
  - OCW2 clears are applied before the acknowledge set. If both target the same bit, the set wins.
  - An OCW2 rotation and an AEOI rotation in the same cycle: OCW2 wins.
  - An IRR set and an acknowledge clear on the same bit: the clear wins. An edge that arrives on that same cycle is lost, as in the original 8259A.
- Priority for the first acknowledge uses the pre-update (current-cycle) register values.

Test Plan:
- Edge mode, IM = 0: pulse IR[3] for 1 cycle -> IRR = 8'h08 next cycle, INT = 1 one cycle later. first_ACK rise -> INT_VEC = 3, ISR = 8'h08, IRR = 0. With AEOI = 0, ISR stays 8'h08 until ocw2 = 8'h20 -> ISR = 0, INT = 0.
- Nesting: IR[5] is in service; raise IR[6] -> INT stays 0. Raise IR[2] -> INT = 1; acknowledge gives INT_VEC = 2, ISR = 8'h24. A non-specific EOI clears bit 2 only (ISR = 8'h20).
- Mask: IM = 8'h10, raise IR[4] -> IRR = 8'h10, INT = 0. Then IM = 0 -> INT = 1 within 1 cycle.
- Rotation: ocw2 = 8'hC4 (set priority, L = 4) -> lowest = 4. Raise IR[0] and IR[6] together -> INT_VEC = 6 on acknowledge. ocw2 = 8'hA0 -> ISR = 0, lowest = 6, so IR7 now has the highest priority.
- AEOI with rot_aeoi: AEOI = 1, ocw2 = 8'h80, service IR1 -> ISR = 0 after second_ACK falls, lowest = 1.
- Spurious / level / reset:
  - LTIM = 1: IR[7] high then dropped before first_ACK -> INT_VEC = 7, ISR = 0.
  - Assert rst_n = 0 mid-acknowledge -> all registers return to their reset values immediately.
